ahb3lite_sram_param: RTL and testbench

AHB3LITE_SRAM_PARAM -- requirements
Module: ahb3lite_sram_param

---
 rtl/ahb3lite_sram_param.sv | 145 ++++++++++++++
 tb/tb_ahb3lite_sram_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_param.sv
`default_nettype none
// ahb3lite_sram_param: AHB3-Lite SRAM slave with programmable wait states; Rev 1.0
// Define AHB_SRAM_ERR_CHECK_EN to return ERROR for out-of-range, oversize or misaligned transfers.
module ahb3lite_sram_param #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR1 = 2'd2, S_ERR2 = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              ready_now, resp_now;
  logic              active, write_q;
  logic [2:0]        size_q;
  logic [AW-1:0]     idx_q;
  logic [LB-1:0]     off_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, bad, we;
  logic [2:0]        size_eff;
  logic [LB-1:0]     low_mask, off_aligned, size_mask_q;
  logic [NB-1:0]     be;

  assign accept      = HSEL & HREADY & HTRANS[1] & (state == S_IDLE);
  assign size_eff    = (HSIZE > 3'(LB)) ? 3'(LB) : HSIZE;
  assign low_mask    = LB'((1 << size_eff) - 1);
  assign off_aligned = HADDR[LB-1:0] & ~low_mask;

`ifdef AHB_SRAM_ERR_CHECK_EN
  assign bad = (HADDR >= 32'(DEPTH * NB)) | (HSIZE > 3'(LB)) |
               ((HADDR[LB-1:0] & LB'((1 << HSIZE) - 1)) != '0);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_now = 1'b1;
    resp_now  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        ready_now = 1'b0;
        if (cnt == 4'd0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
`ifdef AHB_SRAM_ERR_CHECK_EN
      S_ERR1: begin
        ready_now = 1'b0;
        resp_now  = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        resp_now  = 1'b1;
        state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      active  <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      idx_q   <= '0;
      off_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Controls only move when the current data phase is completing.
      if (ready_now) begin
        active <= accept & ~bad;
        if (accept) begin
          write_q <= HWRITE;
          size_q  <= size_eff;
          idx_q   <= HADDR[AW+LB-1:LB];
          off_q   <= off_aligned;
        end
      end
    end
  end

  assign size_mask_q = LB'((1 << size_q) - 1);

  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++) be[b] = ((LB'(b) & ~size_mask_q) == off_q);
  end

  assign we = active & write_q & (state == S_IDLE) & ~HRESET;

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  assign HRDATA    = (active & ~write_q & (state == S_IDLE)) ? mem[idx_q] : '0;
  assign HREADYOUT = ready_now;
`ifdef AHB_SRAM_ERR_CHECK_EN
  assign HRESP = resp_now;
`else
  assign HRESP = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{HBURST, HPROT, HTRANS[0], HADDR[31:AW+LB], resp_now};
endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_sram_param.sv
`default_nettype none
// tb_ahb3lite_sram_param: scoreboard bench for a 32-bit zero-wait and a 64-bit three-wait SRAM slave.
module tb_ahb3lite_sram_param;
  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        sel0 = 1'b0, sel1 = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [1:0]  htrans = '0;
  logic [63:0] hwdata = '0;
  logic        hready;
  logic [31:0] rd0;
  logic [63:0] rd1;
  logic        ro0, ro1, rs0, rs1;

  assign hready = ro0 & ro1;
  always #5 clk = ~clk;

  ahb3lite_sram_param #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'd1), .HPROT(4'd3), .HTRANS(htrans), .HREADY(hready),
    .HWDATA(hwdata[31:0]), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

  ahb3lite_sram_param #(.DATA_W(64), .DEPTH(16), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESET(hreset), .HSEL(sel1), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'd2), .HPROT(4'd3), .HTRANS(htrans), .HREADY(hready),
    .HWDATA(hwdata), .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1));

  typedef struct {
    logic        dut;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic        dut;
    logic        wr;
    logic        resp;
    int          waits;
    logic [63:0] data;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  logic [7:0] m0 [4096];
  logic [7:0] m1 [128];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic d, input logic [31:0] a);
    logic [63:0] w;
    int base;
    w = '0;
    if (!d) begin
      base = int'(a[11:2]) * 4;
      for (int b = 0; b < 4; b++) w[b*8 +: 8] = m0[base + b];
    end else begin
      base = int'(a[6:3]) * 8;
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = m1[base + b];
    end
    return w;
  endfunction

  task automatic model_wr(input logic d, input logic [31:0] a, input logic [2:0] s, input logic [63:0] wd);
    int n, nb, tot, ba;
    n   = 1 << s;
    nb  = d ? 8 : 4;
    tot = d ? 128 : 4096;
    for (int j = 0; j < n; j++) begin
      ba = (int'(a) & ~(n - 1)) + j;
      if (d) m1[ba % tot] = wd[(ba % nb)*8 +: 8];
      else   m0[ba % tot] = wd[(ba % nb)*8 +: 8];
    end
  endtask

  task automatic push_exp(input req_t r);
    exp_t e;
    e.dut   = r.dut;
    e.wr    = r.wr;
    e.resp  = 1'b0;
    e.waits = r.dut ? 3 : 0;
    e.data  = '0;
`ifdef AHB_SRAM_ERR_CHECK_EN
    if (r.dut && r.addr >= 32'd128) begin
      e.resp  = 1'b1;
      e.waits = 1;
    end
`endif
    if (!e.resp) begin
      if (r.wr) model_wr(r.dut, r.addr, r.size, r.wdata);
      else      e.data = model_rd(r.dut, r.addr);
    end
    exp_q.push_back(e);
  endtask

  task automatic add(input logic d, input logic [1:0] t, input logic w, input logic [31:0] a,
                     input logic [2:0] s, input logic [63:0] wd);
    req_t r;
    r.dut = d; r.trans = t; r.wr = w; r.addr = a; r.size = s; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic drive(input req_t r, input bit v);
    sel0   = v && !r.dut;
    sel1   = v && r.dut;
    htrans = v ? r.trans : 2'b00;
    hwrite = v && r.wr;
    haddr  = r.addr;
    hsize  = r.size;
  endtask

  // Pipelined master: address of the next beat overlaps the data phase of the current one.
  task automatic run_queue();
    bit          adv = 1'b1;
    bit          pv = 1'b0;
    bit          dv = 1'b0;
    bit          done = 1'b0;
    bit          rdy;
    req_t        pres;
    exp_t        e;
    logic [63:0] dwd = '0;
    int          dw = 0;
    pres = '{dut: 1'b0, trans: 2'b00, wr: 1'b0, addr: 32'h0, size: 3'd0, wdata: 64'h0};
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(posedge clk); #1;
      if (adv) begin
        dv  = pv && pres.trans[1];
        dwd = pres.wdata;
        dw  = 0;
        if (req_q.size() != 0) begin
          pres = req_q.pop_front();
          pv   = 1'b1;
          if (pres.trans[1]) push_exp(pres);
        end else begin
          pv = 1'b0;
        end
        drive(pres, pv);
      end
      hwdata = dwd;
      rdy = ro0 & ro1;
      if (dv) begin
        if (!rdy) begin
          dw++;
        end else begin
          e = exp_q.pop_front();
          check("waits", 64'(dw), 64'(e.waits));
          check("resp", 64'(e.dut ? rs1 : rs0), 64'(e.resp));
          if (!e.wr && !e.resp) check("rdata", e.dut ? rd1 : {32'h0, rd0}, e.data);
          dv = 1'b0;
        end
      end
      adv  = rdy;
      done = !pv && !dv && (req_q.size() == 0);
    end
    if (!done) check("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {62'h0, ro1, ro0}, 64'h3);
    check("rst_resp", {62'h0, rs1, rs0}, 64'h0);
    check("rst_rdata0", {32'h0, rd0}, 64'h0);
    check("rst_rdata1", rd1, 64'h0);
    @(posedge clk); #1;
    hreset = 1'b0;

    add(0, 2'd2, 1, 32'h10, 3'd2, 64'hDEADBEEF);
    add(0, 2'd2, 0, 32'h10, 3'd2, 64'h0);
    add(0, 2'd2, 1, 32'h10, 3'd2, 64'h11223344);
    add(0, 2'd3, 1, 32'h13, 3'd0, 64'hAA000000);
    add(0, 2'd2, 0, 32'h10, 3'd2, 64'h0);
    add(0, 2'd2, 1, 32'h14, 3'd2, 64'hCAFEF00D);
    add(0, 2'd2, 1, 32'h16, 3'd1, 64'h12340000);
    add(0, 2'd2, 0, 32'h14, 3'd2, 64'h0);
    add(0, 2'd1, 1, 32'h10, 3'd2, 64'hFFFFFFFF);
    add(0, 2'd2, 0, 32'h10, 3'd2, 64'h0);
    add(1, 2'd2, 1, 32'h00, 3'd3, 64'hA5A5A5A5_5A5A5A5A);
    add(1, 2'd2, 1, 32'h10, 3'd3, 64'h01234567_89ABCDEF);
    add(1, 2'd3, 1, 32'h04, 3'd2, 64'h87654321_00000000);
    add(1, 2'd3, 1, 32'h05, 3'd0, 64'h00007700_00000000);
    add(1, 2'd3, 1, 32'h02, 3'd1, 64'h00000000_BEEF0000);
    add(1, 2'd2, 0, 32'h00, 3'd3, 64'h0);
    add(1, 2'd2, 0, 32'h10, 3'd3, 64'h0);
    add(1, 2'd2, 0, 32'h80, 3'd3, 64'h0);
    add(1, 2'd0, 0, 32'h00, 3'd0, 64'h0);
    add(0, 2'd2, 0, 32'h10, 3'd2, 64'h0);
    add(0, 2'd2, 0, 32'h14, 3'd2, 64'h0);
    run_queue();

    // Reset in the second wait cycle of a write must abort it.
    @(posedge clk); #1;
    sel1 = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd3;
    @(posedge clk); #1;
    hwdata = 64'hFFFFFFFF_FFFFFFFF;
    check("rstw_wait1", 64'(ro1), 64'h0);
    @(posedge clk); #1;
    check("rstw_wait2", 64'(ro1), 64'h0);
    hreset = 1'b1; htrans = 2'd0; sel1 = 1'b0; hwrite = 1'b0;
    @(posedge clk); #1;
    hreset = 1'b0;
    check("rstw_ready", 64'(ro1), 64'h1);
    check("rstw_resp", 64'(rs1), 64'h0);
    check("rstw_rdata", rd1, 64'h0);
    add(1, 2'd2, 0, 32'h10, 3'd3, 64'h0);
    add(0, 2'd2, 0, 32'h10, 3'd2, 64'h0);
    run_queue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
